// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port data RAM between the CPU load/store path
// and a DMA engine. One requester is granted per access, the RAM bus is held
// for WAIT_CYCLES+1 cycles, read data is captured into the owner's register and
// a one-cycle acknowledge is returned.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration on
// simultaneous requests; otherwise the CPU always wins.
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpuCe,
  input  logic        cpuWe,
  input  logic [31:0] cpuAddr,
  input  logic [31:0] cpuWtData,
  output logic [31:0] cpuRdData,
  output logic        cpuAck,
  input  logic        dmaCe,
  input  logic        dmaWe,
  input  logic [31:0] dmaAddr,
  input  logic [31:0] dmaWtData,
  output logic [31:0] dmaRdData,
  output logic        dmaAck,
  output logic        ramCe,
  output logic        ramWe,
  output logic [31:0] ramAddr,
  output logic [31:0] ramWtData,
  input  logic [31:0] ramRdData,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             owner;     // 1 = DMA owns the current access
  logic             grantDma;  // IDLE-cycle arbitration result
  logic             anyReq;

`ifdef ARB_ROUND_ROBIN_EN
  logic             lastDma;   // 1 = DMA was the last port served

  // Round-robin: on contention, grant the port not served last
  always_comb begin
    anyReq   = cpuCe | dmaCe;
    grantDma = dmaCe & (~cpuCe | ~lastDma);
  end

  // Last-served pointer, updated once the access has been acknowledged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastDma <= 1'b1;
    end else if (state == RESP) begin
      lastDma <= owner;
    end
  end
`else
  // Fixed priority: DMA only wins when the CPU is not requesting
  always_comb begin
    anyReq   = cpuCe | dmaCe;
    grantDma = dmaCe & ~cpuCe;
  end
`endif

  // Busy flag decoded straight from the state so reset clears it immediately
  always_comb begin
    busy = (state != IDLE);
  end

  // Access sequencer: grant, hold RAM bus, capture read data, acknowledge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= 1'b0;
      ramCe     <= 1'b0;
      ramWe     <= 1'b0;
      ramAddr   <= '0;
      ramWtData <= '0;
      cpuRdData <= '0;
      dmaRdData <= '0;
      cpuAck    <= 1'b0;
      dmaAck    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            owner     <= grantDma;
            ramCe     <= 1'b1;
            ramWe     <= grantDma ? dmaWe     : cpuWe;
            ramAddr   <= grantDma ? dmaAddr   : cpuAddr;
            ramWtData <= grantDma ? dmaWtData : cpuWtData;
            cnt       <= CNT_LOAD;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            if (!ramWe) begin
              if (owner) dmaRdData <= ramRdData;
              else       cpuRdData <= ramRdData;
            end
            ramCe     <= 1'b0;
            ramWe     <= 1'b0;
            ramAddr   <= '0;
            ramWtData <= '0;
            cpuAck    <= ~owner;
            dmaAck    <= owner;
            state     <= RESP;
          end
        end
        RESP: begin
          cpuAck <= 1'b0;
          dmaAck <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          cpuAck <= 1'b0;
          dmaAck <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter (WAIT_CYCLES=2).
// Stimulus pushes the expected acknowledge (port, both RdData values, cycle);
// a negedge monitor pops and compares on every cpuAck/dmaAck.
module tb_mem_arbiter;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seed = 1'b1;
  logic        cpuCe = 1'b0, cpuWe = 1'b0;
  logic [31:0] cpuAddr = '0, cpuWtData = '0;
  logic [31:0] cpuRdData;
  logic        cpuAck;
  logic        dmaCe = 1'b0, dmaWe = 1'b0;
  logic [31:0] dmaAddr = '0, dmaWtData = '0;
  logic [31:0] dmaRdData;
  logic        dmaAck;
  logic        ramCe, ramWe;
  logic [31:0] ramAddr, ramWtData, ramRdData;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit          dma;
    logic [31:0] cpuRd;
    logic [31:0] dmaRd;
    int          expCyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  mem_arbiter #(.WAIT_CYCLES(W), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .cpuCe(cpuCe), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWtData(cpuWtData),
    .cpuRdData(cpuRdData), .cpuAck(cpuAck),
    .dmaCe(dmaCe), .dmaWe(dmaWe), .dmaAddr(dmaAddr), .dmaWtData(dmaWtData),
    .dmaRdData(dmaRdData), .dmaAck(dmaAck),
    .ramCe(ramCe), .ramWe(ramWe), .ramAddr(ramAddr), .ramWtData(ramWtData),
    .ramRdData(ramRdData), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: combinational read, write on clock edge
  logic [31:0] mem [0:255];
  assign ramRdData = mem[ramAddr[9:2]];
  always @(posedge clk) begin
    if (seed) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[16] <= 32'hDEAD_BEEF;            // address 0x40
    end else if (ramCe && ramWe) begin
      mem[ramAddr[9:2]] <= ramWtData;
    end
  end

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Monitor: every acknowledge must match the oldest expected response
  always @(negedge clk) begin
    if (!rst && (cpuAck || dmaAck)) begin
      check32("ack_onehot", {31'b0, cpuAck & dmaAck}, 32'd0);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got cpuAck=%0b dmaAck=%0b at cycle %0d, expected none", cpuAck, dmaAck, cyc);
      end else begin
        mon_e = sbq.pop_front();
        check32("ack_port", {31'b0, dmaAck}, {31'b0, mon_e.dma});
        check32("cpuRdData", cpuRdData, mon_e.cpuRd);
        check32("dmaRdData", dmaRdData, mon_e.dmaRd);
        if (mon_e.expCyc >= 0) check32("ack_cycle", cyc, mon_e.expCyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit dma, input logic [31:0] c, input logic [31:0] d, input int ec);
    exp_t e;
    e.dma = dma; e.cpuRd = c; e.dmaRd = d; e.expCyc = ec;
    sbq.push_back(e);
  endtask

  task automatic cpu_req(input logic we, input logic [31:0] a, input logic [31:0] d);
    cpuCe = 1'b1; cpuWe = we; cpuAddr = a; cpuWtData = d;
  endtask

  task automatic dma_req(input logic we, input logic [31:0] a, input logic [31:0] d);
    dmaCe = 1'b1; dmaWe = we; dmaAddr = a; dmaWtData = d;
  endtask

  // Hold requests until acknowledged, bounded by a cycle budget
  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((cpuCe || dmaCe) && n < budget) begin
      tick();
      n++;
      if (cpuAck) cpuCe = 1'b0;
      if (dmaAck) dmaCe = 1'b0;
    end
    if (cpuCe || dmaCe) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ack after %0d cycles, expected ack", budget);
      cpuCe = 1'b0;
      dmaCe = 1'b0;
    end
  endtask

  initial begin
    int k, ceCnt, ceAny, busyCnt, acks, n;
    logic [31:0] dmaAfter;

    // Reset state
    tick(); tick(); tick();
    seed = 1'b0;
    check32("rst_ramCe", {31'b0, ramCe}, 32'd0);
    check32("rst_ramWe", {31'b0, ramWe}, 32'd0);
    check32("rst_ramAddr", ramAddr, 32'd0);
    check32("rst_ramWtData", ramWtData, 32'd0);
    check32("rst_cpuAck", {31'b0, cpuAck}, 32'd0);
    check32("rst_dmaAck", {31'b0, dmaAck}, 32'd0);
    check32("rst_busy", {31'b0, busy}, 32'd0);
    check32("rst_cpuRdData", cpuRdData, 32'd0);
    check32("rst_dmaRdData", dmaRdData, 32'd0);
    rst = 1'b0;
    tick();

    // Single CPU read of 0x40
    k = cyc;
    cpu_req(1'b0, 32'h0000_0040, 32'h0);
    push(1'b0, 32'hDEAD_BEEF, 32'h0, k + 2 + W);
    tick();
    check32("rd_ramCe", {31'b0, ramCe}, 32'd1);
    check32("rd_ramWe", {31'b0, ramWe}, 32'd0);
    check32("rd_ramAddr", ramAddr, 32'h0000_0040);
    run_until_idle(40);
    tick();

    // DMA write 0x12345678 to 0x100: RAM bus held W+1 cycles, busy W+2 cycles
    dma_req(1'b1, 32'h0000_0100, 32'h1234_5678);
    push(1'b1, 32'hDEAD_BEEF, 32'h0, cyc + 2 + W);
    ceCnt = 0; ceAny = 0; busyCnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ramCe) ceAny++;
      if (ramCe && ramWe && ramAddr == 32'h0000_0100 && ramWtData == 32'h1234_5678) ceCnt++;
      if (busy) busyCnt++;
      if (dmaAck) dmaCe = 1'b0;
    end
    check32("wr_ramCe_cycles", ceAny, W + 1);
    check32("wr_stable_cycles", ceCnt, W + 1);
    check32("wr_busy_cycles", busyCnt, W + 2);

    // DMA read back, then CPU write and read of 0x80
    dma_req(1'b0, 32'h0000_0100, 32'h0);
    push(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, cyc + 2 + W);
    run_until_idle(40);
    tick();
    cpu_req(1'b1, 32'h0000_0080, 32'hCAFE_F00D);
    push(1'b0, 32'hDEAD_BEEF, 32'h1234_5678, cyc + 2 + W);
    run_until_idle(40);
    tick();
    cpu_req(1'b0, 32'h0000_0080, 32'h0);
    push(1'b0, 32'hCAFE_F00D, 32'h1234_5678, cyc + 2 + W);
    run_until_idle(40);
    tick();

    // DMA request rising while the CPU access is in BUSY waits for next IDLE
    k = cyc;
    cpu_req(1'b0, 32'h0000_0040, 32'h0);
    push(1'b0, 32'hDEAD_BEEF, 32'h1234_5678, k + 2 + W);
    push(1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D, k + 5 + 2 * W);
    tick();
    dma_req(1'b0, 32'h0000_0080, 32'h0);
    run_until_idle(40);
    tick();

    // Both ports requesting continuously for six accesses
    k = cyc;
    cpu_req(1'b0, 32'h0000_0040, 32'h0);
    dma_req(1'b0, 32'h0000_0100, 32'h0);
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (i % 2 == 0) push(1'b0, 32'hDEAD_BEEF, (i == 0) ? 32'hCAFE_F00D : 32'h1234_5678, k + 2 + W + i * (W + 3));
      else            push(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, k + 2 + W + i * (W + 3));
`else
      push(1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D, k + 2 + W + i * (W + 3));
`endif
    end
`ifdef ARB_ROUND_ROBIN_EN
    dmaAfter = 32'h1234_5678;
`else
    dmaAfter = 32'hCAFE_F00D;
`endif
    acks = 0; n = 0;
    while (acks < 6 && n < 100) begin
      tick();
      n++;
      if (cpuAck || dmaAck) acks++;
    end
    cpuCe = 1'b0;
    dmaCe = 1'b0;
    check32("contention_acks", acks, 6);
    tick();
    check32("contention_dmaRdData", dmaRdData, dmaAfter);

    // Reset in the second BUSY cycle of a read: everything clears at once
    cpu_req(1'b0, 32'h0000_0080, 32'h0);
    tick();
    tick();
    check32("pre_rst_ramCe", {31'b0, ramCe}, 32'd1);
    rst = 1'b1;
    cpuCe = 1'b0;
    #1;
    check32("midrst_ramCe", {31'b0, ramCe}, 32'd0);
    check32("midrst_ramWe", {31'b0, ramWe}, 32'd0);
    check32("midrst_ramAddr", ramAddr, 32'd0);
    check32("midrst_ramWtData", ramWtData, 32'd0);
    check32("midrst_busy", {31'b0, busy}, 32'd0);
    check32("midrst_cpuAck", {31'b0, cpuAck}, 32'd0);
    check32("midrst_cpuRdData", cpuRdData, 32'd0);
    check32("midrst_dmaRdData", dmaRdData, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    cpu_req(1'b0, 32'h0000_0040, 32'h0);
    push(1'b0, 32'hDEAD_BEEF, 32'h0, cyc + 2 + W);
    run_until_idle(40);
    for (int i = 0; i < 8; i++) tick();

    // Every expected acknowledge must have been seen
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check32("scoreboard_empty", sbq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and access sequencer that shares one single-port data RAM between the CPU load/store path and a DMA engine. Each requester presents a held request; the block grants one, drives the RAM for a configurable number of cycles, captures read data, and returns a one-cycle acknowledge. It sits between the CPU memory stage and DMA on one side and the RAM-side chip-enable/write-enable bus on the other.

## Interface
- `WAIT_CYCLES`, 0: extra cycles the RAM signals are held beyond the first; set ≥1 for synchronous-read RAM.
- `CNT_W`, 4: width of the wait counter; `WAIT_CYCLES` ≤ 2^`CNT_W`−1.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cpuCe` in 1: CPU request, held until `cpuAck`.
- `cpuWe` in 1: CPU write (1) / read (0).
- `cpuAddr` in 32: CPU address.
- `cpuWtData` in 32: CPU write data.
- `cpuRdData` out 32: CPU read data, registered.
- `cpuAck` out 1: one-cycle completion pulse to CPU.
- `dmaCe`, `dmaWe`, `dmaAddr`, `dmaWtData`, `dmaRdData`, `dmaAck`: same as CPU set, for the DMA port.
- `ramCe` out 1: RAM chip enable.
- `ramWe` out 1: RAM write enable.
- `ramAddr` out 32: RAM address.
- `ramWtData` out 32: RAM write data.
- `ramRdData` in 32: RAM read data.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- Reset values: all outputs 0; state IDLE; counter 0; round-robin pointer = "DMA last served".
- States: IDLE, BUSY, RESP.
- IDLE: if no request, stay. Otherwise select winner (see Configuration), latch its we/addr/wtData into `ramWe`/`ramAddr`/`ramWtData`, set `ramCe`=1, counter=`WAIT_CYCLES`, record owner, go BUSY.
- BUSY: RAM outputs held constant. If counter≠0, decrement. If counter=0: on read, capture `ramRdData` into the owner's RdData register; clear `ramCe`, `ramWe`, `ramAddr`, `ramWtData` to 0; assert owner's Ack; go RESP.
- RESP: owner's Ack high for exactly this cycle; update round-robin pointer to owner; go IDLE.
- Non-owner RdData never changes; RdData holds its value until that port's next read. Writes leave RdData unchanged.
- Requests are sampled only in IDLE; a request rising in BUSY/RESP waits. Requesters change we/addr/wtData only after their Ack.
- A requester still asserting Ce in the IDLE cycle after its Ack starts a new access.
- Simultaneous requests in IDLE: exactly one granted; the loser stays pending and is granted on the next IDLE (round-robin) or when the CPU is idle (fixed priority).

## Timing
- Request sampled at IDLE cycle N; `ramCe` high cycles N+1 … N+1+`WAIT_CYCLES`; Ack high in cycle N+2+`WAIT_CYCLES`; IDLE again at N+3+`WAIT_CYCLES`.
- Read data sampled at the edge ending the last BUSY cycle; valid on RdData from the Ack cycle onward.
- Back-to-back throughput: one access per `WAIT_CYCLES`+3 cycles.
- `rst` asserted mid-access: all outputs and state return to reset values immediately, no Ack issued, in-flight access abandoned; `ramCe` deasserts without waiting for an edge.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: on simultaneous requests, grant the port not recorded as last served; pointer updated in RESP.
- Not defined: fixed priority, CPU always wins; pointer logic absent; DMA served only in IDLE cycles with `cpuCe`=0.

## Test plan
- Single CPU read, `WAIT_CYCLES`=0, `cpuAddr`=0x0000_0040, RAM returns 0xDEAD_BEEF -> `ramCe` high 1 cycle with `ramAddr`=0x40, `ramWe`=0, `cpuAck` 2 cycles after sample, `cpuRdData`=0xDEAD_BEEF, `dmaRdData` unchanged.
- DMA write, `WAIT_CYCLES`=2, addr 0x100, data 0x1234_5678 -> `ramCe`/`ramWe` high 3 cycles with stable addr/data, `dmaAck` pulse in cycle N+4, `busy` high 4 cycles.
- Both request every cycle for 6 accesses, round-robin defined -> grants alternate CPU, DMA, CPU…, CPU first after reset; without macro -> 6 CPU grants, no DMA Ack.
- Request rising while BUSY -> ignored until IDLE, then granted; no Ack lost or duplicated.
- `rst` pulsed in second BUSY cycle of a `WAIT_CYCLES`=3 read -> all outputs 0 at once, no Ack, next request after release completes normally.
